// File: rtl/adex_spike_pkg.sv
// Shared defaults and types for the AdEx spike ISI logger slice.
package adex_spike_pkg;

   localparam int TS_W_DEF  = 8;
   localparam int DEPTH_DEF = 8;
   localparam int PRE_W_DEF = 4;
   localparam int RATE_WIN  = 256;

   localparam logic [TS_W_DEF-1:0] ISI_MAX = TS_W_DEF'((1 << TS_W_DEF) - 1);

   typedef logic [TS_W_DEF-1:0] isi_t;

endpackage

// File: rtl/adex_isi_fifo.sv
// Generic first-word-fall-through FIFO with flush, drop-on-full and a sticky overflow flag.
module adex_isi_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_en;
   logic          pop_en;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign pop_en  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign push_en = push & (~full | pop_en);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
         if (push_en && !pop_en)      count <= count + (AW+1)'(1);
         else if (pop_en && !push_en) count <= count - (AW+1)'(1);
         if (push && !push_en) overflow <= 1'b1;
      end
   end

   // NOTE: storage has no reset; entries are only visible through the reset-controlled pointers.
   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= push_data;
   end

   assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/adex_spike_isi_logger.sv
// Spike edge detector and inter-spike-interval logger with host FIFO readout.
// Optional spike-rate window counter enabled by defining ADEX_SPIKE_RATE_EN.
module adex_spike_isi_logger
   import adex_spike_pkg::*;
#(
   parameter int TS_W  = TS_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int PRE_W = PRE_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     spike_i,
   input  logic [PRE_W-1:0]         prescale_i,
   input  logic                     clear_i,
   input  logic                     ev_ready_i,
   output logic                     ev_valid_o,
   output logic [TS_W-1:0]          ev_data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o,
   output logic [7:0]               rate_o
);

   logic             spike_q;
   logic             spk_edge;
   logic             push;
   logic             tick;
   logic             fifo_empty;
   logic             fifo_full;
   logic [PRE_W-1:0] pre_cnt;
   logic [PRE_W-1:0] pre_lim;
   logic [TS_W-1:0]  isi_cnt;
   logic [TS_W-1:0]  isi_now;

   assign spk_edge = spike_i & ~spike_q;
   assign push     = spk_edge & ~clear_i;
   // pre_lim shadows prescale_i so a new setting only applies from the next wrap.
   assign tick     = (pre_cnt == pre_lim);
   assign isi_now  = (tick && isi_cnt != '1) ? isi_cnt + TS_W'(1) : isi_cnt;

   // spike_q ignores clear so a level held across a flush is not logged twice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) spike_q <= 1'b0;
      else        spike_q <= spike_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         pre_lim <= '0;
         isi_cnt <= '0;
      end else if (clear_i) begin
         pre_cnt <= '0;
         pre_lim <= '0;
         isi_cnt <= '0;
      end else begin
         if (tick) begin
            pre_cnt <= '0;
            pre_lim <= prescale_i;
         end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
         end
         isi_cnt <= spk_edge ? '0 : isi_now;
      end
   end

   adex_isi_fifo #(
      .W     (TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (clear_i),
      .push      (push),
      .push_data (isi_now),
      .pop       (ev_ready_i),
      .head      (ev_data_o),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (count_o),
      .overflow  (overflow_o)
   );

   assign ev_valid_o = ~fifo_empty;

`ifdef ADEX_SPIKE_RATE_EN
   localparam int WIN_W = $clog2(RATE_WIN);

   logic [WIN_W-1:0] win_cnt;
   logic [7:0]       spk_cnt;
   logic [7:0]       spk_inc;
   logic [7:0]       rate_q;
   logic             win_wrap;

   assign win_wrap = tick & (win_cnt == '1);
   assign spk_inc  = (spk_edge && spk_cnt != 8'hFF) ? spk_cnt + 8'd1 : spk_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt <= '0;
         spk_cnt <= '0;
         rate_q  <= '0;
      end else if (clear_i) begin
         win_cnt <= '0;
         spk_cnt <= '0;
         rate_q  <= '0;
      end else begin
         if (tick) win_cnt <= win_cnt + WIN_W'(1);
         if (win_wrap) begin
            rate_q  <= spk_inc;
            spk_cnt <= {7'd0, spk_edge};
         end else begin
            spk_cnt <= spk_inc;
         end
      end
   end

   assign rate_o = rate_q;
`else
   assign rate_o = '0;
`endif

   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_adex_spike_isi_logger.sv
// Self-checking bench for adex_spike_isi_logger: directed scenarios plus randomized traffic vs a behavioural model.
module tb_adex_spike_isi_logger;
   import adex_spike_pkg::*;

   localparam int DEPTH  = DEPTH_DEF;
   localparam int ISI_MX = (1 << TS_W_DEF) - 1;
`ifdef ADEX_SPIKE_RATE_EN
   localparam bit RATE_ON = 1'b1;
`else
   localparam bit RATE_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spike_i = 1'b0;
   logic [3:0] prescale_i = '0;
   logic       clear_i = 1'b0;
   logic       ev_ready_i = 1'b0;
   logic       ev_valid_o;
   logic [7:0] ev_data_o;
   logic [3:0] count_o;
   logic       overflow_o;
   logic [7:0] rate_o;

   int errors = 0;
   int checks = 0;
   int got_q[$];

   // Behavioural reference: tick bookkeeping, interval arithmetic and a queue for the FIFO.
   bit m_spk_q;
   bit m_ovf;
   int m_ticks, m_last, m_phase, m_period, m_win, m_spk, m_rate;
   int m_q[$];

   always #5 clk = ~clk;

   adex_spike_isi_logger dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spike_i    (spike_i),
      .prescale_i (prescale_i),
      .clear_i    (clear_i),
      .ev_ready_i (ev_ready_i),
      .ev_valid_o (ev_valid_o),
      .ev_data_o  (ev_data_o),
      .count_o    (count_o),
      .overflow_o (overflow_o),
      .rate_o     (rate_o)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int gq(input int i);
      return (i < got_q.size()) ? got_q[i] : -1;
   endfunction

   function automatic void model_clear();
      m_q.delete();
      m_ovf = 0; m_ticks = 0; m_last = 0; m_phase = 0; m_period = 0;
      m_win = 0; m_spk = 0; m_rate = 0;
   endfunction

   function automatic void model_reset();
      model_clear();
      m_spk_q = 0;
   endfunction

   function automatic void model_update();
      bit rise, tick, do_pop;
      int isi;
      rise    = spike_i && !m_spk_q;
      m_spk_q = spike_i;
      if (clear_i) begin
         model_clear();
         return;
      end
      tick = (m_phase == m_period);
      if (tick) begin
         m_phase  = 0;
         m_period = int'(prescale_i);
         m_ticks++;
         m_win++;
      end else begin
         m_phase++;
      end
      do_pop = ev_ready_i && (m_q.size() > 0);
      isi = 0;
      if (rise) begin
         isi    = (m_ticks - m_last > ISI_MX) ? ISI_MX : m_ticks - m_last;
         m_last = m_ticks;
      end
      if (do_pop) void'(m_q.pop_front());
      if (rise) begin
         if (m_q.size() < DEPTH) m_q.push_back(isi);
         else                    m_ovf = 1;
      end
      if (tick && (m_win % RATE_WIN) == 0) begin
         m_rate = (m_spk + int'(rise) > 255) ? 255 : m_spk + int'(rise);
         m_spk  = int'(rise);
      end else if (rise) begin
         m_spk = (m_spk >= 255) ? 255 : m_spk + 1;
      end
   endfunction

   task automatic compare_all();
      check("valid", ev_valid_o, (m_q.size() > 0) ? 1 : 0);
      check("data",  ev_data_o,  (m_q.size() > 0) ? m_q[0] : 0);
      check("count", count_o,    m_q.size());
      check("ovf",   overflow_o, m_ovf);
      check("rate",  rate_o,     RATE_ON ? m_rate : 0);
   endtask

   // Inputs are stable here; a handshake at the coming edge is logged before the edge.
   task automatic step();
      if (ev_valid_o && ev_ready_i) got_q.push_back(int'(ev_data_o));
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      spike_i = 1'b0;
      clear_i = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      got_q.delete();
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_full[9] = '{2, 3, 4, 5, 6, 7, 8, 9, 5};
      int p_spk, p_rdy;

      // Basic ISI at prescale 0 with immediate readout
      prescale_i = 4'd0;
      ev_ready_i = 1'b1;
      do_reset();
      check("rst_valid", ev_valid_o, 0);
      check("rst_data",  ev_data_o,  0);
      check("rst_count", count_o,    0);
      check("rst_ovf",   overflow_o, 0);
      check("rst_rate",  rate_o,     0);
      for (int c = 1; c <= 40; c++) begin
         spike_i = (c == 10 || c == 15 || c == 35);
         step();
         if (c == 9)  check("basic_valid_c10", ev_valid_o, 0);
         if (c == 10) check("basic_valid_c11", ev_valid_o, 1);
      end
      spike_i = 1'b0;
      step();
      check("basic_n",  got_q.size(), 3);
      check("basic_e0", gq(0), 10);
      check("basic_e1", gq(1), 5);
      check("basic_e2", gq(2), 20);

      // Prescale 3, saturated long gap, then a 40-cycle gap
      prescale_i = 4'd3;
      do_reset();
      for (int c = 1; c <= 2050; c++) begin
         spike_i = (c == 5 || c == 2005 || c == 2045);
         step();
      end
      check("pre_n",   got_q.size(), 3);
      check("pre_sat", gq(1), 255);
      check("pre_40",  gq(2), 10);

      // Fill with no readout, overflow, then push+pop at full
      prescale_i = 4'd0;
      ev_ready_i = 1'b0;
      do_reset();
      for (int c = 1; c <= 58; c++) begin
         spike_i = (c == 2 || c == 5 || c == 9 || c == 14 || c == 20 ||
                    c == 27 || c == 35 || c == 44 || c == 54);
         step();
      end
      check("full_count", count_o, 8);
      check("full_ovf",   overflow_o, 1);
      check("full_head",  ev_data_o, 2);
      ev_ready_i = 1'b1;
      spike_i    = 1'b1;
      step();
      check("pp_count", count_o, 8);
      check("pp_ovf",   overflow_o, 1);
      spike_i = 1'b0;
      repeat (12) step();
      check("drain_n", got_q.size(), 9);
      for (int i = 0; i < 9; i++) check($sformatf("drain_e%0d", i), gq(i), exp_full[i]);
      check("drain_count", count_o, 0);

      // Clear with coincident rising spike held high, then a 6-cycle pulse
      ev_ready_i = 1'b0;
      for (int k = 0; k <= 20; k++) begin
         clear_i = (k == 0);
         spike_i = (k <= 5) || (k >= 10 && k <= 15);
         step();
         if (k == 0) begin
            check("clr_count", count_o, 0);
            check("clr_ovf",   overflow_o, 0);
            check("clr_valid", ev_valid_o, 0);
         end
         if (k == 9) check("clr_held_no_event", count_o, 0);
      end
      clear_i = 1'b0;
      check("pulse_count", count_o, 1);
      check("pulse_isi",   ev_data_o, 10);

      // Async reset in the middle of a pop
      for (int k = 21; k <= 30; k++) begin
         spike_i = (k == 24 || k == 27);
         step();
      end
      spike_i    = 1'b0;
      ev_ready_i = 1'b1;
      step();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", ev_valid_o, 0);
      check("arst_data",  ev_data_o,  0);
      check("arst_count", count_o,    0);
      check("arst_ovf",   overflow_o, 0);
      check("arst_rate",  rate_o,     0);
      do_reset();
      for (int c = 1; c <= 9; c++) begin
         spike_i = (c == 7);
         step();
      end
      check("arst_n",   got_q.size(), 1);
      check("arst_isi", gq(0), 7);

      // Rate window: 12 spikes in the first 256 ticks after a clear
      spike_i = 1'b0;
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      for (int k = 1; k <= 260; k++) begin
         spike_i = (k % 10 == 0) && (k <= 120);
         step();
         if (k == 255) check("rate_pre_wrap", rate_o, 0);
         if (k == 256) check("rate_wrap", rate_o, RATE_ON ? 12 : 0);
      end
      check("rate_hold", rate_o, RATE_ON ? 12 : 0);

      // Randomized traffic against the reference model
      for (int seg = 0; seg < 10; seg++) begin
         prescale_i = 4'($urandom_range(0, 15));
         if (seg % 3 == 0) prescale_i = 4'($urandom_range(0, 2));
         p_spk = (seg % 4 == 0) ? 2 : (seg % 4 == 1) ? 8 : (seg % 4 == 2) ? 25 : 50;
         p_rdy = $urandom_range(5, 95);
         for (int k = 0; k < 400; k++) begin
            spike_i    = ($urandom_range(0, 99) < p_spk);
            ev_ready_i = ($urandom_range(0, 99) < p_rdy);
            clear_i    = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) prescale_i = 4'($urandom_range(0, 15));
            step();
         end
      end
      clear_i = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adex_spike_isi_logger.md
Name: adex_spike_isi_logger

Overview:
Downstream consumer of the AdEx neuron core's spike output. Detects spike rising edges and measures the inter-spike interval (ISI) in prescaled ticks. Each ISI is pushed into a small FIFO and drained by the host through a valid/ready read port. Sits between the neuron core and the TinyTapeout output mux, so slow off-chip readout can capture bursty spike trains without losing events.

Parameters:
- TS_W, 8: ISI width in ticks; the ISI saturates at 2^TS_W-1.
- DEPTH, 8: FIFO entries; must be a power of two and at least 2.
- PRE_W, 4: prescaler select width.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- spike_i, input, 1: spike level from the neuron core; may stay high for several cycles.
- prescale_i, input, PRE_W: one tick every prescale_i+1 clk cycles.
- clear_i, input, 1: synchronous flush.
- ev_ready_i, input, 1: host accepts the head entry.
- ev_valid_o, output, 1: FIFO is non-empty.
- ev_data_o, output, TS_W: ISI at the FIFO head.
- count_o, output, $clog2(DEPTH)+1: FIFO occupancy.
- overflow_o, output, 1: sticky; set when an event is dropped.
- rate_o, output, 8: spikes in the last window (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): prescaler, ISI counter, spike_q, FIFO pointers and count, overflow_o and rate state all go to 0. ev_valid_o=0, ev_data_o=0, count_o=0, rate_o=0.
- Edge detect: spike_q <= spike_i every cycle. spk_edge = spike_i & ~spike_q (combinational). Exactly one event per high pulse.
- Prescaler: counts 0..prescale_i, then wraps. tick=1 on the wrap cycle. A prescale_i change takes effect at the next wrap.
- ISI counter:
  - Increments on tick and saturates at 2^TS_W-1 (no wrap).
  - On spk_edge it is loaded with 0. If spk_edge and tick coincide, the load wins and the counter becomes 0.
- Push: on spk_edge, the pre-update ISI value (including this cycle's tick, saturated) is written. The first spike after reset or clear logs the ticks elapsed since then.
- FIFO:
  - First-word fall-through. ev_data_o = mem[rd_ptr] while ev_valid_o; 0 when empty.
  - Pop on ev_valid_o & ev_ready_i.
  - Latency: spk_edge in cycle N gives ev_valid_o=1 and data visible in cycle N+1.
  - Full with push only: event dropped, overflow_o <= 1, contents unchanged.
  - Full with push and pop in the same cycle: both occur, count unchanged, no overflow.
  - Empty with ev_ready_i: no pop, pointers hold.
  - Pointers wrap modulo DEPTH.
- clear_i (synchronous, highest priority after reset): zeroes pointers, count, overflow_o, ISI counter, prescaler and rate state. A coincident spike is ignored. spike_q still updates, so a spike held high across clear is not re-logged.
- overflow_o is cleared only by rst_n or clear_i.

Optional Feature:
- Macro: ADEX_SPIKE_RATE_EN.
- Defined:
  - An 8-bit window counter counts ticks from 0..255.
  - An 8-bit spike counter increments on spk_edge and saturates at 255.
  - On the tick that wraps the window, rate_o <= spike count (including a coincident edge), and the spike counter restarts at 0 (or 1 if an edge coincides).
  - rate_o is held between updates.
- Undefined: rate_o is tied to 0 and no rate logic is synthesized.

Decomposition:
- Package adex_spike_pkg holds:
  - TS_W_DEF=8, DEPTH_DEF=8, PRE_W_DEF=4, RATE_WIN=256;
  - the ISI_MAX localparam expression;
  - typedef isi_t (logic [TS_W-1:0]).
- Sub-module adex_isi_fifo: a generic synchronous FWFT FIFO with push/pop/full/empty/count, flush and drop-on-full.
- Edge detect, prescaler, ISI counter and rate logic stay in the top block.

Test Plan:
- Basic ISI, prescale_i=0, ev_ready_i=1: reset, spike edges at cycles 10, 15 and 35. Events read are 10, 5, 20; ev_valid_o rises in cycle 11.
- Prescale and saturation: prescale_i=3 with a spike 2000 cycles after the previous one gives ISI 255 (saturated). Spikes 40 cycles apart give 10.
- Full FIFO, ev_ready_i=0: 9 spike edges give count_o=8 and overflow_o=1, and the first 8 ISIs are retained in order. Then hold ev_ready_i=1 and apply a simultaneous spike edge with pop at full: count stays 8, no new overflow is raised, and the new entry lands at the tail.
- Long pulse and clear: spike_i held high for 6 cycles produces exactly 1 event. Asserting clear_i mid-stream with a coincident edge gives count_o=0, overflow_o=0, no event, and the next ISI is measured from the clear.
- Async reset: drop rst_n mid-pop, away from any clk edge. All outputs go to 0 immediately, and the first post-reset spike at cycle 7 logs 7.
- Rate (ADEX_SPIKE_RATE_EN): prescale_i=0 with 12 spikes inside one 256-cycle window gives rate_o=12 at the window wrap. Without the macro, rate_o stays 0 throughout.
